// File: rtl/line_clear_ctrl.sv
// Row-clear sequencer for the playfield occupancy store.
// Scans bottom-up, drops full rows, compacts survivors downward, zero-fills the top.
module line_clear_ctrl #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [4:0] lines,
  input  logic       g_we,
  input  logic [3:0] g_wx,
  input  logic [4:0] g_wy,
  input  logic       g_wdata,
  input  logic [3:0] g_rx,
  input  logic [4:0] g_ry,
  output logic       g_rdata,
  output logic       b_we,
  output logic [3:0] b_wx,
  output logic [4:0] b_wy,
  output logic       b_wdata,
  output logic [3:0] b_rx,
  output logic [4:0] b_ry,
  input  logic       b_rdata
);

  localparam logic [3:0] XLAST = 4'(COLS - 1);
  localparam logic [5:0] RLAST = 6'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, READ, EVAL, COPY, FILL, DONE} state_t;

  state_t          state;
  logic [5:0]      src;
  logic [5:0]      dst;
  logic [3:0]      x;
  logic [4:0]      count;
  logic [COLS-1:0] rowbuf;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      src    <= '0;
      dst    <= '0;
      x      <= '0;
      count  <= '0;
      rowbuf <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      lines  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            src   <= RLAST;
            dst   <= RLAST;
            x     <= '0;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        READ: begin
          rowbuf[x] <= b_rdata;
          x         <= x + 4'd1;
          if (x == XLAST) state <= EVAL;
        end
        EVAL: begin
          x <= '0;
          if (&rowbuf) begin
            count <= count + 5'd1;
            src   <= src - 6'd1;
            // Row 0 was full: at least one row cleared, so the top always needs filling.
            state <= (src == 6'd0) ? FILL : READ;
          end else if (src != dst) begin
            state <= COPY;
          end else begin
            src <= src - 6'd1;
            dst <= dst - 6'd1;
            // src==dst implies nothing cleared yet, so reaching row 0 means no fill.
            if (src == 6'd0) begin
              state <= DONE;
              done  <= 1'b1;
              lines <= count;
            end else begin
              state <= READ;
            end
          end
        end
        COPY: begin
          x <= x + 4'd1;
          if (x == XLAST) begin
            x   <= '0;
            src <= src - 6'd1;
            dst <= dst - 6'd1;
            if (src != 6'd0) begin
              state <= READ;
            end else if (count != 5'd0) begin
              state <= FILL;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              lines <= count;
            end
          end
        end
        FILL: begin
          // dst now equals count-1, so rows dst..0 are exactly the vacated rows.
          x <= x + 4'd1;
          if (x == XLAST) begin
            x <= '0;
            if (dst == 6'd0) begin
              state <= DONE;
              done  <= 1'b1;
              lines <= count;
            end else begin
              dst <= dst - 6'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    b_we    = 1'b0;
    b_wx    = '0;
    b_wy    = '0;
    b_wdata = 1'b0;
    b_rx    = '0;
    b_ry    = '0;
    g_rdata = 1'b0;
    case (state)
      IDLE: begin
        b_we    = g_we;
        b_wx    = g_wx;
        b_wy    = g_wy;
        b_wdata = g_wdata;
        b_rx    = g_rx;
        b_ry    = g_ry;
        g_rdata = b_rdata;
      end
      READ: begin
        b_rx = x;
        b_ry = src[4:0];
      end
      COPY: begin
        b_we    = 1'b1;
        b_wx    = x;
        b_wy    = dst[4:0];
        b_wdata = rowbuf[x];
      end
      FILL: begin
        b_we = 1'b1;
        b_wx = x;
        b_wy = dst[4:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl with a behavioural playfield store.
module tb_line_clear_ctrl;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  typedef logic [COLS-1:0] board_t [ROWS];

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       g_we = 1'b0;
  logic [3:0] g_wx = '0;
  logic [4:0] g_wy = '0;
  logic       g_wdata = 1'b0;
  logic [3:0] g_rx = '0;
  logic [4:0] g_ry = '0;
  logic       busy, done, g_rdata, b_we, b_wdata, b_rdata;
  logic [4:0] lines, b_wy, b_ry;
  logic [3:0] b_wx, b_rx;

  line_clear_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done), .lines(lines),
    .g_we(g_we), .g_wx(g_wx), .g_wy(g_wy), .g_wdata(g_wdata), .g_rx(g_rx), .g_ry(g_ry),
    .g_rdata(g_rdata), .b_we(b_we), .b_wx(b_wx), .b_wy(b_wy), .b_wdata(b_wdata),
    .b_rx(b_rx), .b_ry(b_ry), .b_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  logic [COLS-1:0] brd [ROWS];
  always @(posedge clk)
    if (b_we && b_wy < 5'(ROWS) && b_wx < 4'(COLS)) brd[b_wy][b_wx] <= b_wdata;
  assign b_rdata = (b_ry < 5'(ROWS) && b_rx < 4'(COLS)) ? brd[b_ry][b_rx] : 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc, dones, wes, g_hits;
  logic timeout;

  task automatic load_board(input board_t img);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        @(negedge clk);
        g_we = 1'b1; g_wx = 4'(x); g_wy = 5'(y); g_wdata = img[y][x];
      end
    @(negedge clk);
    g_we = 1'b0;
  endtask

  task automatic read_board(output board_t got);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        g_rx = 4'(x); g_ry = 5'(y);
        #1;
        got[y][x] = g_rdata;
      end
  endtask

  // Starts a pass and follows it to completion; inject>0 fires a g_we write and a second start mid-pass.
  task automatic run_pass(input int inject);
    cyc = 0; dones = 0; wes = 0; g_hits = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (busy && cyc < 3000) begin
      cyc++;
      if (done) dones++;
      if (b_we) wes++;
      if (g_rdata !== 1'b0) g_hits++;
      if (cyc == inject) begin
        g_we = 1'b1; g_wx = 4'd5; g_wy = 5'd0; g_wdata = 1'b1; start = 1'b1;
      end
      @(negedge clk);
      g_we = 1'b0; start = 1'b0;
    end
    timeout = (cyc >= 3000);
  endtask

  task automatic test_reset();
    g_we = 1'b1; g_wx = 4'd7; g_wy = 5'd13; g_wdata = 1'b1; g_rx = 4'd2; g_ry = 5'd11;
    repeat (2) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (lines !== 5'd0) $display("FAIL reset_lines got %0d want 0", lines); else pass_cnt++;
    total_cnt++;
    if ({b_we, b_wx, b_wy, b_wdata, b_rx, b_ry} !== {1'b1, 4'd7, 5'd13, 1'b1, 4'd2, 5'd11})
      $display("FAIL idle_passthru got %b/%0d/%0d/%b/%0d/%0d want 1/7/13/1/2/11",
               b_we, b_wx, b_wy, b_wdata, b_rx, b_ry);
    else pass_cnt++;
    g_we = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass(input string name, input board_t img, input board_t exp,
                           input int exp_lines, input int exp_cyc, input int exp_wes);
    board_t got;
    load_board(img);
    run_pass(-1);
    total_cnt++; if (timeout) $display("FAIL %s_timeout busy stuck after %0d cycles", name, cyc); else pass_cnt++;
    total_cnt++; if (cyc != exp_cyc) $display("FAIL %s_busy_cycles got %0d want %0d", name, cyc, exp_cyc); else pass_cnt++;
    total_cnt++; if (dones != 1) $display("FAIL %s_done_pulses got %0d want 1", name, dones); else pass_cnt++;
    total_cnt++; if (wes != exp_wes) $display("FAIL %s_writes got %0d want %0d", name, wes, exp_wes); else pass_cnt++;
    total_cnt++; if (lines !== 5'(exp_lines)) $display("FAIL %s_lines got %0d want %0d", name, lines, exp_lines); else pass_cnt++;
    read_board(got);
    for (int y = 0; y < ROWS; y++) begin
      total_cnt++;
      if (got[y] !== exp[y]) $display("FAIL %s_row%0d got %b want %b", name, y, got[y], exp[y]);
      else pass_cnt++;
    end
  endtask

  task automatic test_clears();
    board_t img, exp;
    foreach (img[y]) begin img[y] = '0; exp[y] = '0; end
    test_pass("empty", img, exp, 0, 221, 0);

    img[19] = '1; img[18] = 10'b0000001000;
    exp[19] = 10'b0000001000;
    test_pass("single", img, exp, 1, 421, 200);

    foreach (img[y]) begin img[y] = '0; exp[y] = '0; end
    img[16] = '1; img[17] = '1; img[18] = '1; img[19] = '1;
    img[15] = 10'b0000000001; img[14] = 10'b1000000000;
    exp[19] = 10'b0000000001; exp[18] = 10'b1000000000;
    test_pass("quad", img, exp, 4, 421, 200);

    foreach (img[y]) begin img[y] = '0; exp[y] = '0; end
    img[19] = '1; img[17] = '1; img[18] = 10'b0101010101;
    exp[19] = 10'b0101010101;
    test_pass("split", img, exp, 2, 421, 200);
  endtask

  task automatic test_busy_ignore();
    board_t img, got;
    foreach (img[y]) img[y] = '0;
    img[19] = '1; img[18] = 10'b0000001000;
    load_board(img);
    g_rx = 4'd3; g_ry = 5'd18;
    #1;
    total_cnt++; if (g_rdata !== 1'b1) $display("FAIL idle_read got %b want 1", g_rdata); else pass_cnt++;
    run_pass(50);
    total_cnt++; if (timeout || cyc != 421) $display("FAIL ign_busy_cycles got %0d want 421", cyc); else pass_cnt++;
    total_cnt++; if (dones != 1) $display("FAIL ign_done_pulses got %0d want 1", dones); else pass_cnt++;
    total_cnt++; if (g_hits != 0) $display("FAIL ign_g_rdata_busy got %0d nonzero want 0", g_hits); else pass_cnt++;
    total_cnt++; if (lines !== 5'd1) $display("FAIL ign_lines got %0d want 1", lines); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ign_restart busy=%b done=%b want 0/0", busy, done);
      else pass_cnt++;
      @(negedge clk);
    end
    g_rx = 4'd3; g_ry = 5'd19;
    #1;
    total_cnt++; if (g_rdata !== 1'b1) $display("FAIL ign_g_rdata_idle got %b want 1", g_rdata); else pass_cnt++;
    read_board(got);
    total_cnt++; if (got[0] !== 10'b0) $display("FAIL ign_dropped_write row0 got %b want 0", got[0]); else pass_cnt++;
    total_cnt++; if (got[19] !== 10'b0000001000) $display("FAIL ign_row19 got %b want 0000001000", got[19]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    board_t img, exp;
    foreach (img[y]) begin img[y] = '0; exp[y] = '0; end
    img[19] = '1; img[18] = 10'b0000001000;
    load_board(img);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    // Busy cycle 26: fourth COPY cycle (x=3); columns 0..2 of row 19 already rewritten.
    for (int i = 1; i < 26; i++) @(negedge clk);
    total_cnt++; if (busy !== 1'b1 || b_we !== 1'b1) $display("FAIL mid_in_copy busy=%b b_we=%b want 1/1", busy, b_we); else pass_cnt++;
    resetn = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL mid_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (lines !== 5'd0) $display("FAIL mid_lines got %0d want 0", lines); else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    exp[19] = 10'b1111111000; exp[18] = 10'b0000001000;
    test_pass("after_reset", exp, exp, 0, 221, 0);
  endtask

  initial begin
    test_reset();
    test_clears();
    test_busy_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/line_clear_ctrl.md
Name: line_clear_ctrl

Overview:
Sequencer that owns the 10x20 playfield occupancy store during row-clear processing and arbitrates its single write port and single combinational read port against the game-side logic (piece lock writes, renderer reads). On a start pulse it scans rows bottom-up (row 19 = bottom, row 0 = top), drops every fully occupied row, compacts the remaining rows downward, zero-fills the vacated top rows, and reports the number of rows cleared. Sits between the game FSM and the playfield store.

Parameters:
COLS, 10, playfield width (must be <=16, fits 4-bit x)
ROWS, 20, playfield height (must be <=32, fits 5-bit y)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  single-cycle request to run a clear pass; sampled only in IDLE
busy  out  1  controller owns the board port
done  out  1  one-cycle pulse at pass completion
lines  out  5  rows cleared by last pass (0..ROWS), held until next start
g_we  in  1  game-side write enable
g_wx  in  4  game-side write column
g_wy  in  5  game-side write row
g_wdata  in  1  game-side write data
g_rx  in  4  game-side read column
g_ry  in  5  game-side read row
g_rdata  out  1  game-side read data
b_we  out  1  board write enable
b_wx  out  4  board write column
b_wy  out  5  board write row
b_wdata  out  1  board write data
b_rx  out  4  board read column
b_ry  out  5  board read row
b_rdata  in  1  board read data (combinational from b_rx/b_ry, same cycle)

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, lines=0, all counters 0. Board contents untouched by this block. Reset mid-pass abandons the pass; board may be partially compacted.
- IDLE: b_* ports pass g_* through combinationally; g_rdata=b_rdata. start=1 -> READ next cycle with src=ROWS-1, dst=ROWS-1, x=0, clear count=0; busy=1 from that cycle.
- While busy: b_* driven by controller; g_we ignored (write dropped, not queued); g_rdata=0; start ignored.
- READ: b_rx=x, b_ry=src; latch b_rdata into rowbuf[x]; x++. After x=COLS-1 -> EVAL. COLS cycles per row.
- EVAL (1 cycle): full = AND of rowbuf.
  - full: count++, src--.
  - not full, src!=dst: -> COPY, x=0.
  - not full, src==dst: src--, dst-- (no write).
  - If the row just evaluated was row 0 and no COPY is pending: -> FILL if count>0, else DONE.
- COPY: b_we=1, b_wx=x, b_wy=dst, b_wdata=rowbuf[x]; x++. After COLS cycles: src--, dst--; then READ (x=0) if more source rows remain, else FILL/DONE per rule above.
- FILL: write 0 to every cell of rows dst down to 0, one cell per cycle, column 0..COLS-1 per row; exactly count rows. -> DONE.
- DONE (1 cycle): done=1, busy=1, lines=count; -> IDLE (busy=0 next cycle).
- src/dst are 6-bit internally so underflow below 0 is detectable; never drive b_wy/b_ry outside 0..ROWS-1; b_we=0 outside COPY/FILL.
- Latency: busy cycles = ROWS*(COLS+1) + COLS*(rows copied) + COLS*count + 1.

Test Plan:
- Empty board, start -> busy high 221 cycles, no b_we ever, done pulse, lines=0; all cells still 0.
- Row 19 full, cell (3,18)=1 -> 421 busy cycles, lines=1; after: (3,19)=1, rest of row 19 = 0, rows 0..18 all 0.
- Rows 16..19 full, (0,15)=1, (9,14)=1 -> lines=4; after: (0,19)=1, (9,18)=1, all other cells 0, rows 0..3 zero.
- Rows 17 and 19 full, row 18 = 10'b0101010101 -> lines=2; row 19 = 10'b0101010101, rows 17,18 empty.
- g_we pulse and second start during pass -> write not applied, pass completes once, one done pulse; g_rdata=0 while busy, matches board after return to IDLE.
- resetn asserted during COPY -> busy=0, done=0, lines=0 immediately; subsequent start on same board completes normally.
